// File: rtl/bt_pipe_out_arbiter.sv
// bt_pipe_out_arbiter -- shares one block-throttled pipe-out endpoint between N_SRC FIFOs, one full block per grant, round-robin.
// Rev 1.0
`timescale 1ns / 1ps
`default_nettype none

module bt_pipe_out_arbiter #(
   parameter int N_SRC       = 4,
   parameter int BLOCK_WORDS = 256,
   parameter int LEVEL_W     = 11,
   parameter int GID_W       = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [N_SRC-1:0]           enable,
   input  logic [N_SRC*LEVEL_W-1:0]   src_level,
   input  logic [N_SRC*16-1:0]        src_data,
   output logic [N_SRC-1:0]           src_read,
   input  logic                       pipe_out_read,
   input  logic                       pipe_out_blockstrobe,
   output logic                       pipe_out_ready,
   output logic [15:0]                pipe_out_data,
   output logic [GID_W-1:0]           grant_id,
   output logic [15:0]                block_count,
   output logic                       proto_err,
   input  logic                       clear_err
);

   localparam int                CNT_W       = $clog2(BLOCK_WORDS);
   localparam logic [CNT_W-1:0]  C_LAST_WORD = CNT_W'(BLOCK_WORDS - 1);
   localparam logic [GID_W-1:0]  C_LAST_SRC  = GID_W'(N_SRC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_XFER  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [GID_W-1:0]  grant_q, grant_d;
   logic [GID_W-1:0]  last_grant_q, last_grant_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [15:0]       block_count_q, block_count_d;
   logic              proto_err_q, proto_err_d;

   logic [N_SRC-1:0]  w_elig;
   logic [15:0]       w_src_word [N_SRC];
   logic              w_found;
   logic [GID_W-1:0]  w_pick;
   int                w_idx;
   logic              w_err;

   generate
      for (genvar k = 0; k < N_SRC; k++) begin : g_src
         assign w_elig[k]     = enable[k] &
                                (32'(src_level[k*LEVEL_W +: LEVEL_W]) >= 32'(BLOCK_WORDS));
         assign w_src_word[k] = src_data[k*16 +: 16];
      end
   endgenerate

   // First eligible source strictly after the last completed grant, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = 0;
      for (int i = 1; i <= N_SRC; i++) begin
         w_idx = (int'(last_grant_q) + i) % N_SRC;
         if (!w_found && w_elig[GID_W'(w_idx)]) begin
            w_found = 1'b1;
            w_pick  = GID_W'(w_idx);
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      last_grant_d   = last_grant_q;
      word_cnt_d     = word_cnt_q;
      block_count_d  = block_count_q;
      pipe_out_ready = 1'b0;
      src_read       = '0;
      pipe_out_data  = 16'h0000;

      case (state_q)
         S_IDLE: begin
            if (w_found) begin
               grant_d = w_pick;
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            pipe_out_ready = 1'b1;
            if (pipe_out_blockstrobe) begin
               state_d    = S_XFER;
               word_cnt_d = '0;
            end else if (!enable[grant_q]) begin
               state_d = S_IDLE;
            end
         end
         S_XFER: begin
            pipe_out_data = w_src_word[grant_q];
            if (pipe_out_read) begin
               src_read[grant_q] = 1'b1;
               word_cnt_d        = word_cnt_q + 1'b1;
               if (word_cnt_q == C_LAST_WORD) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            // Grant is still held so the final word, arriving now, is muxed out.
            pipe_out_data = w_src_word[grant_q];
            block_count_d = block_count_q + 16'd1;
            last_grant_d  = grant_q;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      w_err = (pipe_out_read && (state_q != S_XFER)) ||
              (pipe_out_blockstrobe && (state_q != S_ARMED));
      if (w_err) begin
         proto_err_d = 1'b1;
      end else if (clear_err) begin
         proto_err_d = 1'b0;
      end else begin
         proto_err_d = proto_err_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         grant_q       <= '0;
         last_grant_q  <= C_LAST_SRC;
         word_cnt_q    <= '0;
         block_count_q <= 16'h0000;
         proto_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_grant_q  <= last_grant_d;
         word_cnt_q    <= word_cnt_d;
         block_count_q <= block_count_d;
         proto_err_q   <= proto_err_d;
      end
   end

   assign grant_id    = grant_q;
   assign block_count = block_count_q;
   assign proto_err   = proto_err_q;

endmodule

`default_nettype wire
